// File: rtl/sha256_msg_padder.sv
// -----------------------------------------------------------------------------
// sha256_msg_padder
//   Feeds the SHA-256 core. It takes a raw message as a stream of 32-bit
//   big-endian words and emits the fully padded message as whole 16-word
//   blocks: message bytes, a 0x80 byte, zero fill, then the 64-bit big-endian
//   bit length in words 14/15 of the final block. The message length is not
//   limited; the byte counter wraps modulo 2^CNT_W.
//
// Ports
//   clk, reset_n     clock, asynchronous active-low reset
//   in_valid/ready   input handshake; in_ready only asserted in DATA state
//   in_data          message word, byte0 in [31:24]
//   in_last          final message word
//   in_nbytes        valid bytes in final word (0..4, values >4 treated as 4)
//   out_valid/ready  output handshake (single register stage)
//   out_data         padded message word
//   out_block_last   word 15 of a block
//   out_msg_last     final word of final block
//   busy             message in progress or output word pending
// -----------------------------------------------------------------------------
module sha256_msg_padder #(
    parameter int unsigned CNT_W = 32
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_data,
    input  logic        in_last,
    input  logic [2:0]  in_nbytes,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_data,
    output logic        out_block_last,
    output logic        out_msg_last,
    output logic        busy
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_DATA   = 3'd1;
    localparam logic [2:0] S_PAD80  = 3'd2;
    localparam logic [2:0] S_ZERO   = 3'd3;
    localparam logic [2:0] S_LEN_HI = 3'd4;
    localparam logic [2:0] S_LEN_LO = 3'd5;

    logic [2:0]       r_state;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_widx;
    logic             r_out_valid;
    logic [31:0]      r_out_data;
    logic             r_block_last;
    logic             r_msg_last;

    logic             w_load;
    logic             w_emit;
    logic             w_done;
    logic             w_msg_last;
    logic [31:0]      w_word;
    logic [2:0]       w_state_nxt;
    logic [CNT_W-1:0] w_cnt_nxt;
    logic [2:0]       w_nb;
    logic             w_after_is_14;
    logic [63:0]      w_bitlen;

    assign w_load        = !r_out_valid || out_ready;
    assign in_ready      = (r_state == S_DATA) && w_load;
    assign w_nb          = (in_nbytes > 3'd4) ? 3'd4 : in_nbytes;
    assign w_after_is_14 = (r_widx + 4'd1) == 4'd14;
    assign w_bitlen      = 64'({r_cnt, 3'b000});

    assign out_valid      = r_out_valid;
    assign out_data       = r_out_data;
    assign out_block_last = r_block_last;
    assign out_msg_last   = r_msg_last;
    assign busy           = (r_state != S_IDLE) || r_out_valid;

    always_comb begin
        w_emit      = 1'b0;
        w_done      = 1'b0;
        w_msg_last  = 1'b0;
        w_word      = '0;
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            S_IDLE: begin
                if (in_valid) w_state_nxt = S_DATA;
            end
            S_DATA: begin
                if (in_valid && w_load) begin
                    w_emit = 1'b1;
                    if (!in_last || w_nb == 3'd4) begin
                        w_word    = in_data;
                        w_cnt_nxt = r_cnt + CNT_W'(4);
                        if (in_last) w_state_nxt = S_PAD80;
                    end else begin
                        // Partial last word: keep n bytes, 0x80 at byte n, mask the rest.
                        case (w_nb)
                            3'd1:    w_word = {in_data[31:24], 24'h800000};
                            3'd2:    w_word = {in_data[31:16], 16'h8000};
                            3'd3:    w_word = {in_data[31:8], 8'h80};
                            default: w_word = 32'h8000_0000;
                        endcase
                        w_cnt_nxt   = r_cnt + CNT_W'(w_nb);
                        w_state_nxt = w_after_is_14 ? S_LEN_HI : S_ZERO;
                    end
                end
            end
            S_PAD80: begin
                if (w_load) begin
                    w_emit      = 1'b1;
                    w_word      = 32'h8000_0000;
                    w_state_nxt = w_after_is_14 ? S_LEN_HI : S_ZERO;
                end
            end
            S_ZERO: begin
                // Runs through index 15 into a new block when needed; stops before 14.
                if (w_load) begin
                    w_emit = 1'b1;
                    if (w_after_is_14) w_state_nxt = S_LEN_HI;
                end
            end
            S_LEN_HI: begin
                if (w_load) begin
                    w_emit      = 1'b1;
                    w_word      = w_bitlen[63:32];
                    w_state_nxt = S_LEN_LO;
                end
            end
            S_LEN_LO: begin
                if (w_load) begin
                    w_emit      = 1'b1;
                    w_done      = 1'b1;
                    w_msg_last  = 1'b1;
                    w_word      = w_bitlen[31:0];
                    w_state_nxt = S_IDLE;
                end
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state      <= S_IDLE;
            r_cnt        <= '0;
            r_widx       <= '0;
            r_out_valid  <= 1'b0;
            r_out_data   <= '0;
            r_block_last <= 1'b0;
            r_msg_last   <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_done ? '0 : w_cnt_nxt;
            if (w_emit) begin
                r_out_valid  <= 1'b1;
                r_out_data   <= w_word;
                r_block_last <= (r_widx == 4'd15);
                r_msg_last   <= w_msg_last;
                r_widx       <= w_done ? 4'd0 : r_widx + 4'd1;
            end else if (out_ready) begin
                r_out_valid <= 1'b0;
            end
        end
    end

endmodule
